// File: rtl/clk_tune_ctrl.sv
// clk_tune_ctrl: GPS-disciplined trim loop for the local oscillator.
// It measures system clocks per GPS second from PPS-captured timebase
// counts, derives a saturated 24-bit tune word, and writes that word as two
// 12-bit halves into the misc clock-tune PDM registers over Wishbone.
//
// Ports:
//   clk, rst_n        system clock; asynchronous active-low reset
//   cap_val, cap_stb  PPS-captured count and its one-cycle valid strobe
//   cfg_en            loop enable (level); rising edge loads cfg_init
//   cfg_init          tune word loaded on enable
//   cfg_target        nominal clocks per second
//   cfg_shift         loop gain: correction = err >>> cfg_shift
//   cfg_max_err       measurements with |err| above this are rejected
//   cfg_lock_th       |err| at or below this counts toward lock
//   wb_addr/wb_wdata/wb_we/wb_cyc, wb_ack   Wishbone master port
//   st_tune, st_err, st_rej_cnt, st_locked, st_ovf   status
module clk_tune_ctrl #(
  parameter int unsigned LOCK_N  = 8,
  parameter logic [7:0]  ADDR_LO = 8'h08,
  parameter logic [7:0]  ADDR_HI = 8'h09
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cap_val,
  input  logic        cap_stb,
  input  logic        cfg_en,
  input  logic [23:0] cfg_init,
  input  logic [31:0] cfg_target,
  input  logic [3:0]  cfg_shift,
  input  logic [15:0] cfg_max_err,
  input  logic [15:0] cfg_lock_th,
  output logic [7:0]  wb_addr,
  output logic [31:0] wb_wdata,
  output logic        wb_we,
  output logic        wb_cyc,
  input  logic        wb_ack,
  output logic [23:0] st_tune,
  output logic [31:0] st_err,
  output logic [7:0]  st_rej_cnt,
  output logic        st_locked,
  output logic        st_ovf
);

  localparam int unsigned LCW = $clog2(LOCK_N + 1);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_N);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT_LO, S_INIT_HI, S_FIRST, S_WAIT, S_MEAS, S_UPD, S_WR_LO, S_WR_HI
  } state_e;

  state_e          state_q, state_d;
  logic            cyc_q, cyc_d;
  logic            en_q;
  logic [23:0]     tune_q;
  logic [31:0]     err_q;
  logic [7:0]      rej_q;
  logic            ovf_q;
  logic [31:0]     prev_q, cur_q;
  logic            pend_vld_q;
  logic [31:0]     pend_val_q;
  logic [LCW-1:0]  lock_cnt_q;

  logic               en_rise, busy, stb_any;
  logic [31:0]        stb_val;
  logic [31:0]        err_mag;
  logic               rej_hit, lock_hit;
  logic signed [31:0] corr;
  logic signed [33:0] tune_raw;
  logic [23:0]        tune_clamp;

  assign en_rise = cfg_en & ~en_q;
  // Strobes arriving here must be parked in the pending register.
  assign busy    = state_q inside {S_INIT_LO, S_INIT_HI, S_MEAS, S_UPD, S_WR_LO, S_WR_HI};
  // A parked strobe is older than any new one, so it is consumed first.
  assign stb_any = cap_stb | pend_vld_q;
  assign stb_val = pend_vld_q ? pend_val_q : cap_val;

  // Unsigned magnitude; -2^31 maps to 2^31, which is still correct unsigned.
  assign err_mag  = err_q[31] ? (~err_q + 32'd1) : err_q;
  assign rej_hit  = err_mag > {16'd0, cfg_max_err};
  assign lock_hit = err_mag <= {16'd0, cfg_lock_th};
  assign corr     = $signed(err_q) >>> cfg_shift;
  // 34 bits hold both tune - (-2^31) and 0 - (2^31 - 1) without overflow.
  assign tune_raw = $signed({10'd0, tune_q}) - $signed({{2{corr[31]}}, corr});
  assign tune_clamp = tune_raw[33]         ? 24'h000000 :
                      (|tune_raw[32:24])   ? 24'hFFFFFF : tune_raw[23:0];

  // State register; the bus cycle flag lives here so reset drops wb_cyc at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cyc_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cyc_q   <= cyc_d;
    end
  end

  // Next-state logic. Each write state raises cyc, waits for ack, and leaves
  // with cyc low, which guarantees an idle bus cycle between the two halves.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d = state_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      S_IDLE: if (en_rise) begin
        state_d = S_INIT_LO;
        cyc_d   = 1'b1;
      end
      S_INIT_LO, S_INIT_HI, S_WR_LO, S_WR_HI: begin
        if (cyc_q) begin
          // An in-flight cycle always completes, even when disabling.
          if (wb_ack) begin
            cyc_d = 1'b0;
            if (!cfg_en)                 state_d = S_IDLE;
            else if (state_q == S_INIT_LO) state_d = S_INIT_HI;
            else if (state_q == S_INIT_HI) state_d = S_FIRST;
            else if (state_q == S_WR_LO)   state_d = S_WR_HI;
            else                           state_d = S_WAIT;
          end
        end else if (!cfg_en) begin
          state_d = S_IDLE;
        end else begin
          cyc_d = 1'b1;
        end
      end
      S_FIRST: if (!cfg_en) state_d = S_IDLE; else if (stb_any) state_d = S_WAIT;
      S_WAIT:  if (!cfg_en) state_d = S_IDLE; else if (stb_any) state_d = S_MEAS;
      S_MEAS:  state_d = cfg_en ? S_UPD : S_IDLE;
      S_UPD: begin
        if (!cfg_en)      state_d = S_IDLE;
        else if (rej_hit) state_d = S_WAIT;
        else begin
          state_d = S_WR_LO;
          cyc_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs; address and data depend only on state and tune_q, neither
  // of which changes while cyc is high, so they stay stable for the cycle.
  always_comb begin
    wb_cyc   = cyc_q;
    wb_we    = cyc_q;
    wb_addr  = 8'h00;
    wb_wdata = 32'h0;
    if (cyc_q) begin
      if (state_q == S_INIT_HI || state_q == S_WR_HI) begin
        wb_addr  = ADDR_HI;
        wb_wdata = {1'b1, 19'd0, tune_q[23:12]};
      end else begin
        wb_addr  = ADDR_LO;
        wb_wdata = {1'b1, 19'd0, tune_q[11:0]};
      end
    end
  end

  // Measurement datapath and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      tune_q     <= '0;
      err_q      <= '0;
      rej_q      <= '0;
      ovf_q      <= 1'b0;
      prev_q     <= '0;
      cur_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_val_q <= '0;
      lock_cnt_q <= '0;
    end else begin
      en_q <= cfg_en;
      if (busy && cap_stb && cfg_en) begin
        pend_val_q <= cap_val;
        pend_vld_q <= 1'b1;
        if (pend_vld_q) ovf_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: if (en_rise) begin
          tune_q     <= cfg_init;
          rej_q      <= '0;
          ovf_q      <= 1'b0;
          lock_cnt_q <= '0;
          pend_vld_q <= 1'b0;
        end
        S_FIRST, S_WAIT: if (cfg_en && stb_any) begin
          if (state_q == S_FIRST) prev_q <= stb_val;
          else                    cur_q  <= stb_val;
          // A fresh strobe coinciding with a parked one takes its place.
          pend_vld_q <= pend_vld_q & cap_stb;
          if (pend_vld_q && cap_stb) pend_val_q <= cap_val;
        end
        S_MEAS: begin
          // Modular difference makes wrap of the capture counter transparent.
          err_q  <= (cur_q - prev_q) - cfg_target;
          prev_q <= cur_q;
        end
        S_UPD: if (cfg_en) begin
          if (rej_hit) begin
            if (rej_q != 8'hFF) rej_q <= rej_q + 8'd1;
            lock_cnt_q <= '0;
          end else begin
            tune_q <= tune_clamp;
            if (!lock_hit)                   lock_cnt_q <= '0;
            else if (lock_cnt_q != LOCK_MAX) lock_cnt_q <= lock_cnt_q + LCW'(1);
          end
        end
        default: ;
      endcase
      if (!cfg_en) begin
        pend_vld_q <= 1'b0;
        lock_cnt_q <= '0;
      end
    end
  end

  assign st_tune    = tune_q;
  assign st_err     = err_q;
  assign st_rej_cnt = rej_q;
  assign st_locked  = (lock_cnt_q == LOCK_MAX);
  assign st_ovf     = ovf_q;

endmodule

// File: tb/tb_clk_tune_ctrl.sv
// Testbench for clk_tune_ctrl: a misc-like slave acks one cycle after cyc,
// a bus monitor pops expected writes from a scoreboard queue, a vector table
// covers single-second cases, and hand sequences cover multi-cycle corners.
module tb_clk_tune_ctrl;

  localparam logic [31:0] TARGET = 32'd30_720_000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cap_val = '0;
  logic        cap_stb = 1'b0;
  logic        cfg_en = 1'b0;
  logic [23:0] cfg_init = '0;
  logic [31:0] cfg_target = TARGET;
  logic [3:0]  cfg_shift = 4'd4;
  logic [15:0] cfg_max_err = 16'hFFFF;
  logic [15:0] cfg_lock_th = 16'd10;
  logic [7:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_we, wb_cyc;
  logic        wb_ack;
  logic [23:0] st_tune;
  logic [31:0] st_err;
  logic [7:0]  st_rej_cnt;
  logic        st_locked, st_ovf;

  clk_tune_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cap_val(cap_val), .cap_stb(cap_stb),
    .cfg_en(cfg_en), .cfg_init(cfg_init), .cfg_target(cfg_target),
    .cfg_shift(cfg_shift), .cfg_max_err(cfg_max_err), .cfg_lock_th(cfg_lock_th),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_we(wb_we), .wb_cyc(wb_cyc),
    .wb_ack(wb_ack), .st_tune(st_tune), .st_err(st_err),
    .st_rej_cnt(st_rej_cnt), .st_locked(st_locked), .st_ovf(st_ovf)
  );

  always #5 clk = ~clk;

  // misc slave: ack one cycle after cyc, for one cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb_ack <= 1'b0;
    else        wb_ack <= wb_cyc & ~wb_ack;
  end

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [23:0] init;
    logic [3:0]  shift;
    logic [15:0] max_err;
    logic [31:0] cap_a, cap_b;
    logic [31:0] exp_err;
    logic [23:0] exp_tune;
    logic        exp_rej;
  } vec_t;
  vec_t vecs[9];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_one(input logic [7:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic push_writes(input logic [23:0] t);
    push_one(8'h08, {1'b1, 19'd0, t[11:0]});
    push_one(8'h09, {1'b1, 19'd0, t[23:12]});
  endtask

  // Bus monitor: handshake shape, stability, and scoreboard comparison.
  task automatic monitor();
    int          len = 0;
    logic        gap = 1'b0;
    logic [7:0]  a0 = '0;
    logic [31:0] d0 = '0;
    wr_t         w;
    forever begin
      @(negedge clk);
      if (gap) begin
        check("cyc_gap_after_write", wb_cyc, 0);
        gap = 1'b0;
      end
      if (wb_cyc) begin
        len++;
        if (len == 1) begin
          a0 = wb_addr;
          d0 = wb_wdata;
          check("we_with_cyc", wb_we, 1);
        end else begin
          check("addr_stable", wb_addr, a0);
          check("wdata_stable", wb_wdata, d0);
        end
        if (wb_ack) begin
          check("cyc_width", len, 2);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write", wb_addr, wb_wdata);
          end else begin
            w = exp_q.pop_front();
            check("wr_addr", wb_addr, w.addr);
            check("wr_data", wb_wdata, w.data);
          end
          gap = 1'b1;
          len = 0;
        end
      end else begin
        len = 0;
      end
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || wb_cyc) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || wb_cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: %0d writes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic strobe(input logic [31:0] v);
    @(negedge clk);
    cap_val = v;
    cap_stb = 1'b1;
    @(negedge clk);
    cap_stb = 1'b0;
  endtask

  task automatic enable(input logic [23:0] init);
    @(negedge clk);
    cfg_en = 1'b0;
    repeat (2) @(negedge clk);
    cfg_init = init;
    push_writes(init);
    cfg_en = 1'b1;
    wait_done("init_writes");
    check("tune_after_enable", st_tune, init);
  endtask

  initial begin
    logic [31:0] c;

    vecs[0] = '{24'h800000, 4'd4, 16'hFFFF, 32'd1000, 32'd30_721_160, 32'd160,        24'h7FFFF6, 1'b0};
    vecs[1] = '{24'h000005, 4'd0, 16'hFFFF, 32'd1000, 32'd30_721_160, 32'd160,        24'h000000, 1'b0};
    vecs[2] = '{24'hFFFFF0, 4'd0, 16'hFFFF, 32'd1000, 32'd30_720_900, 32'hFFFFFF9C,   24'hFFFFFF, 1'b0};
    vecs[3] = '{24'h800000, 4'd4, 16'd1000, 32'd1000, 32'd30_726_000, 32'd5000,       24'h800000, 1'b1};
    vecs[4] = '{24'h800000, 4'd4, 16'hFFFF, 32'hFFFFFF00, 32'h01D4BF00, 32'd0,        24'h800000, 1'b0};
    vecs[5] = '{24'h100000, 4'd3, 16'hFFFF, 32'd500,  32'd30_719_700, 32'hFFFFFCE0,   24'h100064, 1'b0};
    vecs[6] = '{24'h000010, 4'd2, 16'hFFFF, 32'd0,    32'd30_719_993, 32'hFFFFFFF9,   24'h000012, 1'b0};
    vecs[7] = '{24'h800000, 4'd0, 16'd1000, 32'd0,    32'd30_721_000, 32'd1000,       24'h7FFC18, 1'b0};
    vecs[8] = '{24'h800000, 4'd0, 16'd1000, 32'd0,    32'd30_718_999, 32'hFFFFFC17,   24'h800000, 1'b1};

    fork
      monitor();
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_cyc", wb_cyc, 0);
    check("rst_we", wb_we, 0);
    check("rst_addr", wb_addr, 0);
    check("rst_wdata", wb_wdata, 0);
    check("rst_tune", st_tune, 0);
    check("rst_err", st_err, 0);
    check("rst_rej", st_rej_cnt, 0);
    check("rst_locked", st_locked, 0);
    check("rst_ovf", st_ovf, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_cyc", wb_cyc, 0);

    // Single-second vectors.
    for (int i = 0; i < 9; i++) begin
      cfg_shift   = vecs[i].shift;
      cfg_max_err = vecs[i].max_err;
      enable(vecs[i].init);
      check($sformatf("v%0d_rej_cleared", i), st_rej_cnt, 0);
      strobe(vecs[i].cap_a);
      repeat (2) @(negedge clk);
      if (!vecs[i].exp_rej) push_writes(vecs[i].exp_tune);
      strobe(vecs[i].cap_b);
      repeat (3) @(negedge clk);
      wait_done($sformatf("v%0d", i));
      check($sformatf("v%0d_err", i), st_err, vecs[i].exp_err);
      check($sformatf("v%0d_tune", i), st_tune, vecs[i].exp_tune);
      check($sformatf("v%0d_rej", i), st_rej_cnt, {7'd0, vecs[i].exp_rej});
      check($sformatf("v%0d_ovf", i), st_ovf, 0);
    end

    // Cycle-accurate timing from the WAIT strobe.
    cfg_shift = 4'd4;
    cfg_max_err = 16'hFFFF;
    enable(24'h800000);
    strobe(32'd1000);
    repeat (2) @(negedge clk);
    push_writes(24'h7FFFF6);
    strobe(32'd30_721_160);
    check("t_e0_cyc", wb_cyc, 0);
    @(negedge clk);
    check("t_e1_err", st_err, 160);
    check("t_e1_tune_old", st_tune, 24'h800000);
    check("t_e1_cyc", wb_cyc, 0);
    @(negedge clk);
    check("t_e2_tune", st_tune, 24'h7FFFF6);
    check("t_e2_cyc", wb_cyc, 1);
    check("t_e2_addr", wb_addr, 8'h08);
    repeat (4) @(negedge clk);
    check("t_e6_hi_cyc", wb_cyc, 1);
    check("t_e6_hi_addr", wb_addr, 8'h09);
    @(negedge clk);
    check("t_e7_hi_done", wb_cyc, 0);
    wait_done("timing");

    // Lock over eight good seconds across a counter wrap, then a reject.
    cfg_max_err = 16'd1000;
    cfg_lock_th = 16'd10;
    enable(24'h800000);
    c = 32'hFFFFFF00;
    strobe(c);
    repeat (2) @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      c = c + TARGET;
      push_writes(24'h800000);
      strobe(c);
      repeat (3) @(negedge clk);
      wait_done("lock");
      check($sformatf("lock%0d_err", k), st_err, 0);
      check($sformatf("lock%0d_locked", k), st_locked, (k >= 8) ? 1 : 0);
    end
    c = c + TARGET + 32'd5000;
    strobe(c);
    repeat (3) @(negedge clk);
    wait_done("reject");
    check("rej_err", st_err, 5000);
    check("rej_cnt", st_rej_cnt, 1);
    check("rej_unlocked", st_locked, 0);
    check("rej_tune", st_tune, 24'h800000);
    c = c + TARGET;
    push_writes(24'h800000);
    strobe(c);
    repeat (3) @(negedge clk);
    wait_done("after_reject");
    check("after_rej_err", st_err, 0);
    check("after_rej_cnt", st_rej_cnt, 1);

    // Two strobes during WR_LO: overflow, and the second one is measured.
    cfg_max_err = 16'hFFFF;
    enable(24'h800000);
    strobe(32'd1000);
    repeat (2) @(negedge clk);
    push_writes(24'h7FFFF6);
    push_writes(24'h800000);
    strobe(32'd30_721_160);
    @(negedge clk);
    @(negedge clk);
    cap_val = 32'd99;
    cap_stb = 1'b1;
    check("ovf_in_wr_lo", wb_cyc, 1);
    @(negedge clk);
    cap_val = 32'd61_441_000;
    @(negedge clk);
    cap_stb = 1'b0;
    repeat (3) @(negedge clk);
    wait_done("ovf");
    check("ovf_flag", st_ovf, 1);
    check("ovf_err", st_err, 32'hFFFFFF60);
    check("ovf_tune", st_tune, 24'h800000);

    // Disable during WR_LO: LO completes, HI is skipped, tune holds.
    enable(24'h800000);
    strobe(32'd1000);
    repeat (2) @(negedge clk);
    push_one(8'h08, 32'h80000FF6);
    strobe(32'd30_721_160);
    @(negedge clk);
    @(negedge clk);
    check("dis_in_wr_lo", wb_cyc, 1);
    cfg_en = 1'b0;
    repeat (6) @(negedge clk);
    wait_done("disable");
    check("dis_cyc_low", wb_cyc, 0);
    check("dis_tune_held", st_tune, 24'h7FFFF6);
    check("dis_unlocked", st_locked, 0);
    strobe(32'd5);
    repeat (4) @(negedge clk);
    check("dis_idle_no_cyc", wb_cyc, 0);

    // Reset mid-write drops cyc asynchronously.
    cfg_init = 24'h123456;
    push_writes(24'h123456);
    cfg_en = 1'b1;
    @(negedge clk);
    check("rstw_cyc_high", wb_cyc, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw_cyc_dropped", wb_cyc, 0);
    check("rstw_we_dropped", wb_we, 0);
    check("rstw_tune", st_tune, 0);
    cfg_en = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstw_idle", wb_cyc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
